demux_route_sched: RTL and testbench
====================================

// Module: demux_route_sched
// PURPOSE
//  Upstream scheduler for the 1-to-4 demux tree (demux_1_4).
//  - Accepts routed bits {dest, data} over a valid/ready handshake and buffers them in a small FIFO.
//  - Presents each entry on the demux control/data lines (sel0, sel1, i) for HOLD cycles, back-to-back.
//  - With nothing to send, drives all lines low, so every demux output reads 0.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  HOLD   1  cycles each entry is driven on sel0/sel1/i; >= 1, <= 255
// PORTS
//  clk        in   1   single clock; all state updates on its rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   producer has an entry on in_dest/in_data
//  in_ready   out  1   FIFO can accept; equals !full (registered occupancy)
//  in_dest    in   2   destination channel 0..3 (y0..y3)
//  in_data    in   1   bit to route
//  sel0       out  1   demux first-stage select = dest[1] of the driven entry
//  sel1       out  1   demux second-stage select = dest[0] of the driven entry
//  i          out  1   demux data input = data of the driven entry
//  out_valid  out  1   sel0/sel1/i carry a live entry this cycle
//  level      out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset
//  - rst sampled high at an edge clears FIFO pointers, level, and hold counter.
//  - Sets state to IDLE and sel0 = sel1 = i = out_valid = 0. in_ready = 1 on the following cycle.
//  - Reset mid-DRIVE discards the driven entry and all buffered entries; no partial completion.
//  Push
//  - A push occurs at an edge where in_valid && in_ready.
//  - When full, in_ready = 0, even if a pop occurs at the same edge (no full pass-through).
//  Pop/load
//  - A load copies the FIFO head into the sel0/sel1/i output registers, sets out_valid = 1, and pops the head at the same edge.
//  - Push and pop at the same edge: level unchanged, both succeed.
//  - Pointers wrap modulo DEPTH.
//  FSM
//  - IDLE: outputs held 0, out_valid = 0.
//    - level != 0 at an edge -> load; hold_cnt <= HOLD-1; go to DRIVE.
//  - DRIVE: outputs held stable.
//    - hold_cnt != 0 -> hold_cnt--.
//    - hold_cnt == 0 and level != 0 -> load the next entry (no gap cycle); stay in DRIVE.
//    - hold_cnt == 0 and level == 0 -> outputs <= 0, out_valid <= 0; go to IDLE.
//  Latency
//  - A push at edge k into an empty IDLE block is loaded at edge k+1.
//  - Outputs are valid from edge k+1 through edge k+1+HOLD.
//  Ordering and throughput
//  - Strict FIFO order.
//  - Steady-state throughput is 1 entry per HOLD cycles.
//  - Channel driven = {sel0, sel1} = in_dest.
//  - In DRIVE, the demux output for that channel equals data; the other three are 0.
//  Registered outputs
//  - All outputs are registered; no combinational path from in_* to sel0/sel1/i/out_valid.
//  - in_ready and level are derived from registered occupancy only.
// CONFIGURATION
//  DEMUX_ROUTE_STATS_EN
//  - Defined: adds output ports ch_cnt0..ch_cnt3 (8 bits each).
//    - The counter for channel {sel0, sel1} increments at each load edge, saturating at 255.
//    - All counters clear on rst.
//  - Undefined: no ports, no counters; all other behaviour is identical.
// TESTING
//  1. Reset: assert rst 2 cycles with in_valid = 1 -> during reset and the cycle after, outputs stay 0 and level = 0; no entry is accepted while rst is high.
//  2. Single entry, HOLD = 1: push {dest = 2, data = 1} at edge k -> sel0 = 1, sel1 = 0, i = 1, out_valid = 1 for exactly one cycle after edge k+1; demux y2 = 1, others 0; then IDLE.
//  3. Back-to-back, HOLD = 3: push dest 0,1,2,3 (data = 1) on consecutive edges -> each driven 3 cycles in order y0, y1, y2, y3; out_valid continuous for 12 cycles; no gap cycle.
//  4. Full, DEPTH = 4, HOLD = 4: push 6 entries back-to-back -> first is loaded, next 4 fill the FIFO; level = 4 and in_ready = 0; the 6th is accepted only after the next pop; order preserved.
//  5. Simultaneous push/pop at level = 2 -> level stays 2; wrap-around across 3 full pointer cycles with no lost or duplicated entries.
//  6. Reset mid-DRIVE with level = 3 -> next cycle outputs 0, level 0; with DEMUX_ROUTE_STATS_EN, counters read 0; 300 loads to channel 1 -> ch_cnt1 = 255.

Source files
------------

// File: rtl/demux_route_sched.sv
// demux_route_sched: buffers routed bits {dest, data} in a small FIFO and
// presents each entry on the demux_1_4 select/data lines for HOLD cycles.
// Optional per-channel load counters are compiled in when DEMUX_ROUTE_STATS_EN
// is defined (adds ports ch_cnt0..ch_cnt3).
module demux_route_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_dest,
  input  logic                         in_data,
  output logic                         sel0,
  output logic                         sel1,
  output logic                         i,
  output logic                         out_valid,
`ifdef DEMUX_ROUTE_STATS_EN
  output logic [7:0]                   ch_cnt0,
  output logic [7:0]                   ch_cnt1,
  output logic [7:0]                   ch_cnt2,
  output logic [7:0]                   ch_cnt3,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned HW = 8;
  localparam int unsigned EW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic [HW-1:0]   hold_q;
  logic [EW-1:0]   head;
  logic            full_c;
  logic            empty_c;
  logic            push_c;
  logic            load_c;
  logic            clear_c;

  assign head     = mem[rd_ptr];
  assign full_c   = (level_q == LW'(DEPTH));
  assign empty_c  = (level_q == '0);
  assign in_ready = !full_c;
  assign level    = level_q;
  assign push_c   = in_valid && !full_c && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave IDLE when data is buffered, return once the last hold expires empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty_c) state_d = DRIVE;
      DRIVE:   if (hold_q == '0 && empty_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode: when to load the FIFO head and when to blank the lines
  always_comb begin
    load_c  = 1'b0;
    clear_c = 1'b0;
    case (state_q)
      IDLE:  load_c = !empty_c;
      DRIVE: begin
        if (hold_q == '0) begin
          if (!empty_c) load_c  = 1'b1;
          else          clear_c = 1'b1;
        end
      end
      default: clear_c = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {in_dest, in_data};
  end

  // Pointers and occupancy; a load pops the head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (load_c) rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, load_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Registered demux lines and hold counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sel0      <= 1'b0;
      sel1      <= 1'b0;
      i         <= 1'b0;
      out_valid <= 1'b0;
      hold_q    <= '0;
    end else if (load_c) begin
      sel0      <= head[2];
      sel1      <= head[1];
      i         <= head[0];
      out_valid <= 1'b1;
      hold_q    <= HW'(HOLD - 1);
    end else if (clear_c) begin
      sel0      <= 1'b0;
      sel1      <= 1'b0;
      i         <= 1'b0;
      out_valid <= 1'b0;
      hold_q    <= '0;
    end else if (state_q == DRIVE && hold_q != '0) begin
      hold_q    <= hold_q - HW'(1);
    end
  end

`ifdef DEMUX_ROUTE_STATS_EN
  logic [7:0] cnt_q [4];

  // Saturating per-channel load counters, indexed by the loaded destination
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else if (load_c && cnt_q[head[2:1]] != 8'hFF) begin
      cnt_q[head[2:1]] <= cnt_q[head[2:1]] + 8'd1;
    end
  end

  assign ch_cnt0 = cnt_q[0];
  assign ch_cnt1 = cnt_q[1];
  assign ch_cnt2 = cnt_q[2];
  assign ch_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_route_sched.sv
// Bench for demux_route_sched: three instances (HOLD = 1, 3, 4) share clock,
// reset and producer stimulus; each scenario checks the instance it targets.
module tb_demux_route_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_dest;
  logic       in_data;

  logic       rdy_1, s0_1, s1_1, i_1, ov_1;
  logic       rdy_3, s0_3, s1_3, i_3, ov_3;
  logic       rdy_4, s0_4, s1_4, i_4, ov_4;
  logic [2:0] lvl_1, lvl_3, lvl_4;
`ifdef DEMUX_ROUTE_STATS_EN
  logic [7:0] c1_0, c1_1, c1_2, c1_3;
  logic [7:0] c3_0, c3_1, c3_2, c3_3;
  logic [7:0] c4_0, c4_1, c4_2, c4_3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_route_sched #(.DEPTH(4), .HOLD(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_1),
    .in_dest(in_dest), .in_data(in_data),
    .sel0(s0_1), .sel1(s1_1), .i(i_1), .out_valid(ov_1),
`ifdef DEMUX_ROUTE_STATS_EN
    .ch_cnt0(c1_0), .ch_cnt1(c1_1), .ch_cnt2(c1_2), .ch_cnt3(c1_3),
`endif
    .level(lvl_1)
  );

  demux_route_sched #(.DEPTH(4), .HOLD(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_3),
    .in_dest(in_dest), .in_data(in_data),
    .sel0(s0_3), .sel1(s1_3), .i(i_3), .out_valid(ov_3),
`ifdef DEMUX_ROUTE_STATS_EN
    .ch_cnt0(c3_0), .ch_cnt1(c3_1), .ch_cnt2(c3_2), .ch_cnt3(c3_3),
`endif
    .level(lvl_3)
  );

  demux_route_sched #(.DEPTH(4), .HOLD(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_4),
    .in_dest(in_dest), .in_data(in_data),
    .sel0(s0_4), .sel1(s1_4), .i(i_4), .out_valid(ov_4),
`ifdef DEMUX_ROUTE_STATS_EN
    .ch_cnt0(c4_0), .ch_cnt1(c4_1), .ch_cnt2(c4_2), .ch_cnt3(c4_3),
`endif
    .level(lvl_4)
  );

  // Two reset edges with the producer idle; returns #1 after the last one
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_dest  = 2'd0;
    in_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_dest  = 2'd3;
    in_data  = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      total++;
      if ({s0_1, s1_1, i_1, ov_1, lvl_1} !== 7'b0) begin
        bad++;
        $display("FAIL reset_hold edge%0d: got %b want 0000000", e, {s0_1, s1_1, i_1, ov_1, lvl_1});
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    total++;
    if (rdy_1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", rdy_1);
    end
    @(posedge clk); #1;
    total++;
    if ({s0_1, s1_1, i_1, ov_1, lvl_1, rdy_1} !== 8'b00000001) begin
      bad++;
      $display("FAIL reset_after: got %b want 00000001", {s0_1, s1_1, i_1, ov_1, lvl_1, rdy_1});
    end
  endtask

  // One entry per destination on the HOLD=1 instance; y model is i shifted to {sel0,sel1}
  task automatic test_single();
    logic [3:0] y;
    logic [3:0] ey;
    for (int d = 0; d < 4; d++) begin
      do_reset();
      in_valid = 1'b1;
      in_dest  = 2'(d);
      in_data  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if ({ov_1, lvl_1} !== 4'b0001) begin
        bad++;
        $display("FAIL single_push d%0d: got ov/lvl %b want 0001", d, {ov_1, lvl_1});
      end
      @(posedge clk); #1;
      ey = 4'b0001 << d;
      y  = 4'(i_1) << {s0_1, s1_1};
      total++;
      if ({s0_1, s1_1, i_1, ov_1} !== {2'(d), 1'b1, 1'b1} || y !== ey || lvl_1 !== 3'd0) begin
        bad++;
        $display("FAIL single_drive d%0d: got lines %b y %b lvl %0d want %b y %b lvl 0",
                 d, {s0_1, s1_1, i_1, ov_1}, y, lvl_1, {2'(d), 2'b11}, ey);
      end
      @(posedge clk); #1;
      total++;
      if ({s0_1, s1_1, i_1, ov_1} !== 4'b0000) begin
        bad++;
        $display("FAIL single_idle d%0d: got %b want 0000", d, {s0_1, s1_1, i_1, ov_1});
      end
    end
  endtask

  // HOLD=3: four pushes on consecutive edges, 12 gapless driven cycles
  task automatic test_back_to_back();
    logic [2:0] ent [4];
    logic [3:0] exp;
    int idx = 0;
    for (int j = 0; j < 4; j++) ent[j] = {2'(j), 1'b1};
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      if (idx < 4) begin
        in_valid = 1'b1;
        {in_dest, in_data} = ent[idx];
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 1 && (c - 1) / 3 < 4) exp = {ent[(c - 1) / 3], 1'b1};
      else                           exp = 4'b0000;
      total++;
      if ({s0_3, s1_3, i_3, ov_3} !== exp) begin
        bad++;
        $display("FAIL b2b cyc%0d: got %b want %b", c, {s0_3, s1_3, i_3, ov_3}, exp);
      end
    end
  endtask

  // HOLD=4: six entries offered with handshake; FIFO fills, sixth waits for a pop
  task automatic test_full();
    logic [2:0] ent [6];
    logic [3:0] exp;
    logic       acc;
    int idx = 0;
    ent[0] = 3'b001; ent[1] = 3'b011; ent[2] = 3'b101;
    ent[3] = 3'b111; ent[4] = 3'b000; ent[5] = 3'b010;
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      if (idx < 6) begin
        in_valid = 1'b1;
        {in_dest, in_data} = ent[idx];
        acc = rdy_4;
      end else begin
        in_valid = 1'b0;
        acc = 1'b0;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (c == 4) begin
        total++;
        if (lvl_4 !== 3'd4 || rdy_4 !== 1'b0) begin
          bad++;
          $display("FAIL full_level: got lvl %0d rdy %b want lvl 4 rdy 0", lvl_4, rdy_4);
        end
      end
      if (c == 5) begin
        total++;
        if (lvl_4 !== 3'd3 || idx != 5) begin
          bad++;
          $display("FAIL full_stall: got lvl %0d accepted %0d want lvl 3 accepted 5", lvl_4, idx);
        end
      end
      if (c == 6) begin
        total++;
        if (lvl_4 !== 3'd4 || idx != 6) begin
          bad++;
          $display("FAIL full_refill: got lvl %0d accepted %0d want lvl 4 accepted 6", lvl_4, idx);
        end
      end
      if (c >= 1 && (c - 1) / 4 < 6) exp = {ent[(c - 1) / 4], 1'b1};
      else                           exp = 4'b0000;
      total++;
      if ({s0_4, s1_4, i_4, ov_4} !== exp) begin
        bad++;
        $display("FAIL full_order cyc%0d: got %b want %b", c, {s0_4, s1_4, i_4, ov_4}, exp);
      end
    end
  endtask

  // HOLD=3: push on each pop edge at level 2; 14 entries wrap the pointers 3+ times
  task automatic test_wrap();
    logic [2:0] ent [14];
    logic [3:0] exp;
    int idx = 0;
    for (int j = 0; j < 14; j++) ent[j] = {2'(j % 4), 1'((j >> 2) & 1)};
    do_reset();
    for (int c = 0; c <= 43; c++) begin
      if (idx < 14 && (c <= 2 || (c >= 4 && (c - 4) % 3 == 0))) begin
        in_valid = 1'b1;
        {in_dest, in_data} = ent[idx];
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 2 && c <= 34) begin
        total++;
        if (lvl_3 !== 3'd2) begin
          bad++;
          $display("FAIL wrap_level cyc%0d: got %0d want 2", c, lvl_3);
        end
      end
      if (c >= 1 && (c - 1) / 3 < 14) exp = {ent[(c - 1) / 3], 1'b1};
      else                            exp = 4'b0000;
      total++;
      if ({s0_3, s1_3, i_3, ov_3} !== exp) begin
        bad++;
        $display("FAIL wrap_order cyc%0d: got %b want %b", c, {s0_3, s1_3, i_3, ov_3}, exp);
      end
    end
  endtask

  // HOLD=4: reset while driving with three entries buffered
  task automatic test_reset_mid();
    do_reset();
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_dest  = 2'(j);
      in_data  = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (lvl_4 !== 3'd3 || ov_4 !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup: got lvl %0d ov %b want lvl 3 ov 1", lvl_4, ov_4);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 0; e < 3; e++) begin
      total++;
      if ({s0_4, s1_4, i_4, ov_4, lvl_4} !== 7'b0) begin
        bad++;
        $display("FAIL mid_cleared cyc%0d: got %b want 0000000", e, {s0_4, s1_4, i_4, ov_4, lvl_4});
      end
      @(posedge clk); #1;
    end
`ifdef DEMUX_ROUTE_STATS_EN
    total++;
    if ({c4_0, c4_1, c4_2, c4_3} !== 32'd0) begin
      bad++;
      $display("FAIL mid_counters: got %h want 00000000", {c4_0, c4_1, c4_2, c4_3});
    end
`endif
  endtask

`ifdef DEMUX_ROUTE_STATS_EN
  // HOLD=1: 302 consecutive loads to channel 1 saturate ch_cnt1
  task automatic test_stats();
    do_reset();
    in_valid = 1'b1;
    in_dest  = 2'd1;
    in_data  = 1'b1;
    repeat (302) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({c1_0, c1_1, c1_2, c1_3} !== {8'd0, 8'd255, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL stats_sat: got %h want 00ff0000", {c1_0, c1_1, c1_2, c1_3});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wrap();
    test_reset_mid();
`ifdef DEMUX_ROUTE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
